// File: rtl/dmem_sb_pkg.sv
// Shared types and defaults for the Dmem posted-write store buffer.
// The entry layout follows SB_ADDR_W/SB_DATA_W; instances use these widths.
package dmem_sb_pkg;

    localparam int SB_ADDR_W = 14;
    localparam int SB_DATA_W = 32;

    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:2] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sb_match_find.sv
// Word-address compare of a load against every buffered store, plus a
// youngest-match priority encoder walking entries in age order from head.
module sb_match_find
    import dmem_sb_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int ADDR_W = SB_ADDR_W,
    localparam int PW     = ptr_w(DEPTH)
) (
    input  logic                         en,
    input  logic [DEPTH-1:0]             ent_valid,
    input  logic [DEPTH-1:0][ADDR_W-3:0] ent_addr,
    input  logic [PW-1:0]                head,
    input  logic [ADDR_W-3:0]            addr,
    output logic                         hit,
    output logic [PW-1:0]                index,
    output logic                         any_match
);

    logic [DEPTH-1:0] match;
    logic [PW-1:0]    slot;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = ent_valid[i] && (ent_addr[i] == addr);
        end
    end

    assign any_match = |match;
    assign hit       = en && any_match;

    // Later (younger) matches overwrite earlier ones as we walk away from head.
    always_comb begin
        index = head;
        slot  = head;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head + PW'(k);
            if (match[slot]) begin
                index = slot;
            end
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer sharing one Dmem port between in-order drains and loads.
// Define DMEM_SB_FORWARD_EN to forward buffered data to matching loads instead of stalling them.
module dmem_store_buffer
    import dmem_sb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_ready,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_ready,
    output logic              ld_valid,
    output logic [DATA_W-1:0] ld_data,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              empty
);

    localparam int            PW       = ptr_w(DEPTH);
    localparam int            CW       = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

`ifdef DMEM_SB_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    sb_entry_t                    entries [DEPTH];
    logic [PW-1:0]                head;
    logic [PW-1:0]                tail;
    logic [CW-1:0]                count;
    logic                         full;
    logic                         push;
    logic                         pop;
    logic                         ld_fire;
    logic                         fwd_sel;
    logic [DEPTH-1:0]             ent_valid;
    logic [DEPTH-1:0][ADDR_W-3:0] ent_addr;
    logic                         match_hit;
    logic                         match_any;
    logic [PW-1:0]                match_idx;
    logic                         unused_addr_bits;

    assign full             = (count == FULL_CNT);
    assign empty            = (count == '0);
    assign st_ready         = !full;
    assign push             = st_valid && st_ready;
    assign ld_fire          = ld_req && ld_ready;
    assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid[i] = entries[i].valid;
            ent_addr[i]  = entries[i].addr;
        end
    end

    sb_match_find #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_match (
        .en        (ld_req),
        .ent_valid (ent_valid),
        .ent_addr  (ent_addr),
        .head      (head),
        .addr      (ld_addr[ADDR_W-1:2]),
        .hit       (match_hit),
        .index     (match_idx),
        .any_match (match_any)
    );

    // NOTE: every output of this block is given a default first, so no branch can infer a latch.
    always_comb begin
        pop       = 1'b0;
        ld_ready  = 1'b0;
        fwd_sel   = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        if (full) begin
            pop = 1'b1;
        end else if (ld_req) begin
            if (!match_any) begin
                ld_ready = 1'b1;
                mem_re   = 1'b1;
                mem_addr = {ld_addr[ADDR_W-1:2], 2'b00};
            end else if (FWD_EN) begin
                ld_ready = 1'b1;
                fwd_sel  = match_hit;
                pop      = 1'b1;
            end else begin
                // A stalled load yields the port so its matching entries can drain.
                pop = 1'b1;
            end
        end else if (!empty) begin
            pop = 1'b1;
        end

        if (pop) begin
            mem_we    = 1'b1;
            mem_addr  = {entries[head].addr, 2'b00};
            mem_wdata = entries[head].data;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop updates from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            ld_valid <= 1'b0;
            ld_data  <= '0;
            // NOTE: the array is tiny, so payload is reset with valid to keep drain data deterministic.
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (push) begin
                entries[tail] <= '{valid: 1'b1, addr: st_addr[ADDR_W-1:2], data: st_data};
                tail          <= tail + PW'(1);
            end
            if (pop) begin
                entries[head].valid <= 1'b0;
                head                <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            ld_valid <= ld_fire;
            if (ld_fire) begin
                ld_data <= fwd_sel ? entries[match_idx].data : mem_rdata;
            end
        end
    end

endmodule
